// File: rtl/fib_controller.sv
// Control FSM for the Fibonacci datapath: sequences register-file loads and
// ALU operations so that R1 ends holding F(n) mod 2^size.
module fib_controller #(
    parameter int         size   = 4,
    parameter logic [2:0] OP_ADD = 3'b000,
    parameter logic [2:0] OP_SUB = 3'b001
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [size-1:0] n,
    input  logic            zero_flag,
    output logic [1:0]      wrt_addr,
    output logic [1:0]      rd_addr1,
    output logic [1:0]      rd_addr2,
    output logic            wrt_en,
    output logic            load_data,
    output logic [2:0]      alu_opcode,
    output logic [size-1:0] count,
    output logic            busy,
    output logic            done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_N,
        S_LOAD_ONE,
        S_INIT_A,
        S_INIT_B,
        S_CHECK,
        S_ADD,
        S_FIX,
        S_DONE
    } state_t;

    // Register map: R0 down-counter, R1 F(k), R2 F(k-1), R3 constant 1.
    localparam logic [1:0] R_CNT = 2'd0;
    localparam logic [1:0] R_FK  = 2'd1;
    localparam logic [1:0] R_FK1 = 2'd2;
    localparam logic [1:0] R_ONE = 2'd3;

    state_t          state_q, state_d;
    logic [size-1:0] n_q, n_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        wrt_addr   = 2'd0;
        rd_addr1   = 2'd0;
        rd_addr2   = 2'd0;
        wrt_en     = 1'b0;
        load_data  = 1'b0;
        alu_opcode = OP_ADD;
        count      = '0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    n_d     = n;
                    state_d = S_LOAD_N;
                end
            end
            S_LOAD_N: begin
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = R_CNT;
                count     = n_q;
                state_d   = S_LOAD_ONE;
            end
            S_LOAD_ONE: begin
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = R_ONE;
                count     = size'(1);
                state_d   = S_INIT_A;
            end
            S_INIT_A: begin
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = R_FK1;
                count     = '0;
                state_d   = S_INIT_B;
            end
            S_INIT_B: begin
                // F(0)=0 finishes here, so the counter is never decremented past zero.
                wrt_en    = 1'b1;
                load_data = 1'b1;
                wrt_addr  = R_FK;
                count     = (n_q == '0) ? '0 : size'(1);
                state_d   = (n_q == '0) ? S_DONE : S_CHECK;
            end
            S_CHECK: begin
                wrt_en     = 1'b1;
                rd_addr1   = R_CNT;
                rd_addr2   = R_ONE;
                wrt_addr   = R_CNT;
                alu_opcode = OP_SUB;
                state_d    = zero_flag ? S_DONE : S_ADD;
            end
            S_ADD: begin
                wrt_en     = 1'b1;
                rd_addr1   = R_FK;
                rd_addr2   = R_FK1;
                wrt_addr   = R_FK;
                alu_opcode = OP_ADD;
                state_d    = S_FIX;
            end
            S_FIX: begin
                // R1 already holds the new sum, so R1-R2 recovers the old R1.
                wrt_en     = 1'b1;
                rd_addr1   = R_FK;
                rd_addr2   = R_FK1;
                wrt_addr   = R_FK1;
                alu_opcode = OP_SUB;
                state_d    = S_CHECK;
            end
            S_DONE: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fib_controller.sv
// Bench for fib_controller: a behavioural register-file/ALU model closes the
// loop on zero_flag; directed vectors check result, latency and output sequence.
module tb_fib_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] n;
    logic       zero_flag;
    logic [1:0] wrt_addr, rd_addr1, rd_addr2;
    logic       wrt_en, load_data;
    logic [2:0] alu_opcode;
    logic [3:0] count;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fib_controller #(.size(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n         (n),
        .zero_flag (zero_flag),
        .wrt_addr  (wrt_addr),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .wrt_en    (wrt_en),
        .load_data (load_data),
        .alu_opcode(alu_opcode),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    // Datapath model: 4-entry register file, ALU with combinational zero flag.
    logic [3:0] rf [4] = '{4'hA, 4'h5, 4'h7, 4'hC};
    logic [3:0] alu_y;

    always_comb begin
        alu_y     = (alu_opcode == 3'b000) ? rf[rd_addr1] + rf[rd_addr2]
                                           : rf[rd_addr1] - rf[rd_addr2];
        zero_flag = (alu_y == 4'd0);
    end

    always @(posedge clk) begin
        if (wrt_en) rf[wrt_addr] <= load_data ? count : alu_y;
    end

    logic [16:0] outs;
    assign outs = {wrt_addr, rd_addr1, rd_addr2, wrt_en, load_data, alu_opcode, count, busy, done};

    typedef struct {
        logic [3:0] nv;
        logic [3:0] data;
        logic [3:0] r2;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected output word for cycle k after the accept edge (k=0: idle before start).
    function automatic logic [16:0] exp_out(input int k, input int lat, input logic [3:0] nv);
        int m;
        if (k == 0)   return 17'd0;
        if (k == lat) return 17'd1;
        case (k)
            1: return {2'd0, 2'd0, 2'd0, 1'b1, 1'b1, 3'b000, nv, 1'b1, 1'b0};
            2: return {2'd3, 2'd0, 2'd0, 1'b1, 1'b1, 3'b000, 4'd1, 1'b1, 1'b0};
            3: return {2'd2, 2'd0, 2'd0, 1'b1, 1'b1, 3'b000, 4'd0, 1'b1, 1'b0};
            4: return {2'd1, 2'd0, 2'd0, 1'b1, 1'b1, 3'b000,
                       (nv == 4'd0) ? 4'd0 : 4'd1, 1'b1, 1'b0};
            default: ;
        endcase
        m = (k - 5) % 3;
        if (m == 0) return {2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 3'b001, 4'd0, 1'b1, 1'b0};
        if (m == 1) return {2'd1, 2'd1, 2'd2, 1'b1, 1'b0, 3'b000, 4'd0, 1'b1, 1'b0};
        return {2'd2, 2'd1, 2'd2, 1'b1, 1'b0, 3'b001, 4'd0, 1'b1, 1'b0};
    endfunction

    // One start request; noisy keeps start high and n=3 after acceptance, through DONE.
    task automatic run(input logic [3:0] nv, input int exp_lat, input bit noisy,
                       output int lat, output int seq_err);
        seq_err = 0;
        lat     = 0;
        @(negedge clk);
        if (outs !== exp_out(0, exp_lat, nv)) seq_err++;
        start = 1'b1;
        n     = nv;
        for (int k = 1; k <= exp_lat + 6; k++) begin
            @(negedge clk);
            if (outs !== exp_out(k, exp_lat, nv)) begin
                seq_err++;
                $display("cycle %0d n=%0d outputs %h expected %h", k, nv, outs, exp_out(k, exp_lat, nv));
            end
            if (done) begin
                lat = k;
                break;
            end
            if (noisy) begin
                start = 1'b1;
                n     = 4'd3;
            end else begin
                start = 1'b0;
            end
        end
        repeat (2) begin
            @(negedge clk);
            if (outs !== 17'd0) seq_err++;
            start = 1'b0;
        end
    endtask

    task automatic check_run(input string tag, input logic [3:0] nv, input logic [3:0] data,
                             input logic [3:0] r2, input int exp_lat, input bit noisy);
        int lat, se;
        run(nv, exp_lat, noisy, lat, se);
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " data R1"}, int'(rf[1]), int'(data));
        chk({tag, " R2"},      int'(rf[2]), int'(r2));
        chk({tag, " R0"},      int'(rf[0]), 0);
        chk({tag, " seq"},     se, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] snap;
        int          dn;

        vecs[0] = '{nv: 4'd0,  data: 4'd0,  r2: 4'd0, lat: 5};
        vecs[1] = '{nv: 4'd1,  data: 4'd1,  r2: 4'd0, lat: 6};
        vecs[2] = '{nv: 4'd2,  data: 4'd1,  r2: 4'd1, lat: 9};
        vecs[3] = '{nv: 4'd3,  data: 4'd2,  r2: 4'd1, lat: 12};
        vecs[4] = '{nv: 4'd5,  data: 4'd5,  r2: 4'd3, lat: 18};
        vecs[5] = '{nv: 4'd7,  data: 4'd13, r2: 4'd8, lat: 24};
        vecs[6] = '{nv: 4'd9,  data: 4'd2,  r2: 4'd5, lat: 30};
        vecs[7] = '{nv: 4'd15, data: 4'd2,  r2: 4'd9, lat: 48};

        // Reset held with start high: controller idle, datapath untouched.
        rst_n = 1'b0;
        start = 1'b1;
        n     = 4'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy",   int'(busy),   0);
        chk("reset done",   int'(done),   0);
        chk("reset wrt_en", int'(wrt_en), 0);
        chk("reset outputs", int'(outs), 0);
        chk("reset regs", int'({rf[3], rf[2], rf[1], rf[0]}), 16'hC75A);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset idle", int'(outs), 0);

        for (int i = 0; i < 8; i++) begin
            check_run($sformatf("n=%0d", vecs[i].nv), vecs[i].nv, vecs[i].data,
                      vecs[i].r2, vecs[i].lat, 1'b0);
        end

        // start held and n changed during the run are ignored.
        check_run("noisy n=5", 4'd5, 4'd5, 4'd3, 18, 1'b1);
        check_run("after noisy n=3", 4'd3, 4'd2, 4'd1, 12, 1'b0);

        // Reset mid-run aborts with no further writes and no done pulse.
        @(negedge clk);
        start = 1'b1;
        n     = 4'd6;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort busy",   int'(busy),   0);
        chk("abort wrt_en", int'(wrt_en), 0);
        chk("abort done",   int'(done),   0);
        snap  = {rf[3], rf[2], rf[1], rf[0]};
        rst_n = 1'b1;
        dn    = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        chk("abort quiet", dn, 0);
        chk("abort regs held", int'({rf[3], rf[2], rf[1], rf[0]}), int'(snap));
        check_run("after abort n=4", 4'd4, 4'd3, 4'd2, 15, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
